// File: rtl/game_pkg.sv
// Shared state encoding and default timing constants for the game flow controller.
package game_pkg;

  typedef enum logic [3:0] {
    ST_MENU       = 4'd0,
    ST_START      = 4'd1,
    ST_PLAYING    = 4'd2,
    ST_PAUSED     = 4'd3,
    ST_RESPAWN    = 4'd4,
    ST_LEVEL_DONE = 4'd5,
    ST_LEVEL_WAIT = 4'd6,
    ST_OVER_DELAY = 4'd7,
    ST_GAME_OVER  = 4'd8,
    ST_GAME_WIN   = 4'd9
  } game_state_e;

  localparam int DEF_NUM_LEVELS    = 10;
  localparam int DEF_NUM_LIVES     = 3;
  localparam int DEF_DONE_DELAY    = 12500000;
  localparam int DEF_OVER_DELAY    = 12500000;
  localparam int DEF_RESPAWN_DELAY = 6250000;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle between keyboard/playfield blocks and the game flow controller.
interface game_flow_ctrl_if #(
  parameter int LEVEL_W = 4,
  parameter int LIVES_W = 2,
  parameter int ENEMY_W = 6
);

  logic               space_i;
  logic               pause_i;
  logic               bullet_collide_eagle_i;
  logic               bullet_collide_player_i;
  logic [ENEMY_W-1:0] enemy_left_i;

  logic               is_menu_o;
  logic               is_playing_o;
  logic               is_paused_o;
  logic               is_respawn_o;
  logic               is_level_done_o;
  logic               is_game_over_o;
  logic               is_game_win_o;
  logic               reset_game_o;
  logic [LEVEL_W-1:0] level_o;
  logic [LIVES_W-1:0] lives_o;
  logic [3:0]         state_o;

  // The controller side: consumes key/collision inputs, drives phase flags.
  modport master (
    input  space_i, pause_i, bullet_collide_eagle_i, bullet_collide_player_i, enemy_left_i,
    output is_menu_o, is_playing_o, is_paused_o, is_respawn_o, is_level_done_o,
    output is_game_over_o, is_game_win_o, reset_game_o, level_o, lives_o, state_o
  );

  modport slave (
    output space_i, pause_i, bullet_collide_eagle_i, bullet_collide_player_i, enemy_left_i,
    input  is_menu_o, is_playing_o, is_paused_o, is_respawn_o, is_level_done_o,
    input  is_game_over_o, is_game_win_o, reset_game_o, level_o, lives_o, state_o
  );

endinterface

// File: rtl/key_edge.sv
// Rising-edge detector for a key level; history resets high so a key held
// through reset does not produce a spurious press.
module key_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_rise
);

  logic r_key_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key_q <= 1'b1;
    end else begin
      r_key_q <= i_key;
    end
  end

  assign o_rise = i_key & ~r_key_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game phase sequencer: menu, play, pause, respawn, level-done,
// game-over and win, with registered phase flags, level and lives tracking.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
  parameter int LEVEL_W       = 4,
  parameter int NUM_LIVES     = DEF_NUM_LIVES,
  parameter int LIVES_W       = 2,
  parameter int ENEMY_W       = 6,
  parameter int CNT_W         = 24,
  parameter int DONE_DELAY    = DEF_DONE_DELAY,
  parameter int OVER_DELAY    = DEF_OVER_DELAY,
  parameter int RESPAWN_DELAY = DEF_RESPAWN_DELAY
) (
  input  logic            clk_i,
  input  logic            reset_i,
  game_flow_ctrl_if.master gf_bus
);

  localparam logic [LEVEL_W-1:0] LEVEL_ONE    = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_LAST   = LEVEL_W'(NUM_LEVELS);
  localparam logic [LIVES_W-1:0] LIVES_FULL   = LIVES_W'(NUM_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);
  localparam logic [CNT_W-1:0]   DONE_LAST    = CNT_W'(DONE_DELAY - 1);
  localparam logic [CNT_W-1:0]   OVER_LAST    = CNT_W'(OVER_DELAY - 1);
  localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_DELAY - 1);

  logic w_space_rise;
  logic w_pause_rise;

  game_state_e        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEVEL_W-1:0] r_level;
  logic [LIVES_W-1:0] r_lives;
  logic               r_is_menu;
  logic               r_is_playing;
  logic               r_is_paused;
  logic               r_is_respawn;
  logic               r_is_level_done;
  logic               r_is_game_over;
  logic               r_is_game_win;
  logic               r_reset_game;

  key_edge u_space_edge (
    .i_clk  (clk_i),
    .i_rst  (reset_i),
    .i_key  (gf_bus.space_i),
    .o_rise (w_space_rise)
  );

  key_edge u_pause_edge (
    .i_clk  (clk_i),
    .i_rst  (reset_i),
    .i_key  (gf_bus.pause_i),
    .o_rise (w_pause_rise)
  );

  // Flags are decoded from the state held during the cycle, so they trail
  // the state register by one clock. The counter is zero on entry to any
  // timed state and the exit fires on DELAY-1, giving exactly DELAY cycles.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= ST_MENU;
      r_cnt           <= '0;
      r_level         <= LEVEL_ONE;
      r_lives         <= LIVES_FULL;
      r_is_menu       <= 1'b0;
      r_is_playing    <= 1'b0;
      r_is_paused     <= 1'b0;
      r_is_respawn    <= 1'b0;
      r_is_level_done <= 1'b0;
      r_is_game_over  <= 1'b0;
      r_is_game_win   <= 1'b0;
      r_reset_game    <= 1'b1;
    end else begin
      r_is_menu       <= 1'b0;
      r_is_playing    <= 1'b0;
      r_is_paused     <= 1'b0;
      r_is_respawn    <= 1'b0;
      r_is_level_done <= 1'b0;
      r_is_game_over  <= 1'b0;
      r_is_game_win   <= 1'b0;
      r_reset_game    <= 1'b1;
      r_cnt           <= '0;

      case (r_state)
        ST_MENU: begin
          r_is_menu <= 1'b1;
          r_level   <= LEVEL_ONE;
          r_lives   <= LIVES_FULL;
          if (w_space_rise) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          r_state <= ST_PLAYING;
        end

        ST_PLAYING: begin
          r_reset_game <= 1'b0;
          r_is_playing <= 1'b1;
          if (gf_bus.bullet_collide_eagle_i) begin
            r_state <= ST_OVER_DELAY;
          end else if (gf_bus.enemy_left_i == '0) begin
            r_state <= ST_LEVEL_DONE;
          end else if (gf_bus.bullet_collide_player_i) begin
            // Last life lost goes straight to game over; lives floor at zero.
            if (r_lives <= LIVES_ONE) begin
              r_lives <= '0;
              r_state <= ST_OVER_DELAY;
            end else begin
              r_lives <= r_lives - 1'b1;
              r_state <= ST_RESPAWN;
            end
          end else if (w_pause_rise) begin
            r_state <= ST_PAUSED;
          end
        end

        ST_PAUSED: begin
          r_reset_game <= 1'b0;
          r_is_paused  <= 1'b1;
          if (w_pause_rise || w_space_rise) begin
            r_state <= ST_PLAYING;
          end
        end

        ST_RESPAWN: begin
          r_reset_game <= 1'b0;
          r_is_respawn <= 1'b1;
          if (gf_bus.bullet_collide_eagle_i) begin
            r_state <= ST_OVER_DELAY;
          end else if (r_cnt == RESPAWN_LAST) begin
            r_state <= ST_PLAYING;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_LEVEL_DONE: begin
          r_is_level_done <= 1'b1;
          if (r_cnt == DONE_LAST) begin
            r_state <= (r_level == LEVEL_LAST) ? ST_GAME_WIN : ST_LEVEL_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_LEVEL_WAIT: begin
          r_is_level_done <= 1'b1;
          if (w_space_rise) begin
            if (r_level < LEVEL_LAST) begin
              r_level <= r_level + 1'b1;
            end
            r_state <= ST_START;
          end
        end

        ST_OVER_DELAY: begin
          // Playfield stays out of reset so the final frame is frozen on screen.
          r_reset_game   <= 1'b0;
          r_is_game_over <= 1'b1;
          if (r_cnt == OVER_LAST) begin
            r_state <= ST_GAME_OVER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_GAME_OVER: begin
          r_is_game_over <= 1'b1;
          if (w_space_rise) begin
            r_state <= ST_MENU;
          end
        end

        ST_GAME_WIN: begin
          r_is_game_win <= 1'b1;
          if (w_space_rise) begin
            r_state <= ST_MENU;
          end
        end

        default: begin
          r_state <= ST_MENU;
        end
      endcase
    end
  end

  assign gf_bus.is_menu_o       = r_is_menu;
  assign gf_bus.is_playing_o    = r_is_playing;
  assign gf_bus.is_paused_o     = r_is_paused;
  assign gf_bus.is_respawn_o    = r_is_respawn;
  assign gf_bus.is_level_done_o = r_is_level_done;
  assign gf_bus.is_game_over_o  = r_is_game_over;
  assign gf_bus.is_game_win_o   = r_is_game_win;
  assign gf_bus.reset_game_o    = r_reset_game;
  assign gf_bus.level_o         = r_level;
  assign gf_bus.lives_o         = r_lives;
  assign gf_bus.state_o         = r_state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios then randomized play, all
// checked cycle by cycle against a phase/countdown reference model.
module tb_game_flow_ctrl;

  localparam int NUM_LEVELS    = 2;
  localparam int NUM_LIVES     = 2;
  localparam int DONE_DELAY    = 4;
  localparam int OVER_DELAY    = 3;
  localparam int RESPAWN_DELAY = 2;

  // Phase numbering follows the published state_o encoding.
  localparam int P_MENU = 0, P_START = 1, P_PLAY = 2, P_PAUSE = 3, P_RESP = 4;
  localparam int P_LDONE = 5, P_LWAIT = 6, P_OVERD = 7, P_GOVER = 8, P_WIN = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  int m_ph, m_timer, m_level, m_lives;
  bit m_sp_q, m_pz_q;
  bit e_menu, e_play, e_pause, e_resp, e_ldone, e_over, e_win, e_rg;

  game_flow_ctrl_if #(.LEVEL_W(4), .LIVES_W(2), .ENEMY_W(6)) gf_bus ();

  game_flow_ctrl #(
    .NUM_LEVELS    (NUM_LEVELS),
    .LEVEL_W       (4),
    .NUM_LIVES     (NUM_LIVES),
    .LIVES_W       (2),
    .ENEMY_W       (6),
    .CNT_W         (24),
    .DONE_DELAY    (DONE_DELAY),
    .OVER_DELAY    (OVER_DELAY),
    .RESPAWN_DELAY (RESPAWN_DELAY)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .gf_bus  (gf_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_MENU; m_timer = 0; m_level = 1; m_lives = NUM_LIVES;
    m_sp_q = 1'b1; m_pz_q = 1'b1;
    {e_menu, e_play, e_pause, e_resp, e_ldone, e_over, e_win} = '0;
    e_rg = 1'b1;
  endtask

  // One clock of the game rules: flags describe the phase occupied during
  // the cycle, phase/level/lives describe the situation after the edge.
  task automatic model_step(input bit sp, input bit pz, input bit eg, input bit pl, input int en);
    bit sr, pr;
    sr = sp && !m_sp_q;
    pr = pz && !m_pz_q;
    m_sp_q = sp;
    m_pz_q = pz;
    e_menu  = (m_ph == P_MENU);
    e_play  = (m_ph == P_PLAY);
    e_pause = (m_ph == P_PAUSE);
    e_resp  = (m_ph == P_RESP);
    e_ldone = (m_ph == P_LDONE) || (m_ph == P_LWAIT);
    e_over  = (m_ph == P_OVERD) || (m_ph == P_GOVER);
    e_win   = (m_ph == P_WIN);
    e_rg    = !(m_ph == P_PLAY || m_ph == P_PAUSE || m_ph == P_RESP || m_ph == P_OVERD);
    case (m_ph)
      P_MENU: begin
        m_level = 1; m_lives = NUM_LIVES;
        if (sr) m_ph = P_START;
      end
      P_START: m_ph = P_PLAY;
      P_PLAY: begin
        if (eg) begin m_ph = P_OVERD; m_timer = OVER_DELAY; end
        else if (en == 0) begin m_ph = P_LDONE; m_timer = DONE_DELAY; end
        else if (pl) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_ph = P_OVERD; m_timer = OVER_DELAY; end
          else begin m_ph = P_RESP; m_timer = RESPAWN_DELAY; end
        end
        else if (pr) m_ph = P_PAUSE;
      end
      P_PAUSE: if (pr || sr) m_ph = P_PLAY;
      P_RESP: begin
        if (eg) begin m_ph = P_OVERD; m_timer = OVER_DELAY; end
        else begin
          m_timer--;
          if (m_timer == 0) m_ph = P_PLAY;
        end
      end
      P_LDONE: begin
        m_timer--;
        if (m_timer == 0) m_ph = (m_level == NUM_LEVELS) ? P_WIN : P_LWAIT;
      end
      P_LWAIT: if (sr) begin m_level++; m_ph = P_START; end
      P_OVERD: begin
        m_timer--;
        if (m_timer == 0) m_ph = P_GOVER;
      end
      default: if (sr) m_ph = P_MENU;
    endcase
  endtask

  task automatic compare_all();
    check("state",      32'(gf_bus.state_o),         32'(m_ph));
    check("is_menu",    32'(gf_bus.is_menu_o),       32'(e_menu));
    check("is_playing", 32'(gf_bus.is_playing_o),    32'(e_play));
    check("is_paused",  32'(gf_bus.is_paused_o),     32'(e_pause));
    check("is_respawn", 32'(gf_bus.is_respawn_o),    32'(e_resp));
    check("is_ldone",   32'(gf_bus.is_level_done_o), 32'(e_ldone));
    check("is_over",    32'(gf_bus.is_game_over_o),  32'(e_over));
    check("is_win",     32'(gf_bus.is_game_win_o),   32'(e_win));
    check("reset_game", 32'(gf_bus.reset_game_o),    32'(e_rg));
    check("level",      32'(gf_bus.level_o),         32'(m_level));
    check("lives",      32'(gf_bus.lives_o),         32'(m_lives));
  endtask

  task automatic cyc(input bit sp, input bit pz, input bit eg, input bit pl, input int en);
    gf_bus.space_i                 = sp;
    gf_bus.pause_i                 = pz;
    gf_bus.bullet_collide_eagle_i  = eg;
    gf_bus.bullet_collide_player_i = pl;
    gf_bus.enemy_left_i            = 6'(en);
    @(posedge clk);
    #1;
    model_step(sp, pz, eg, pl, en);
    compare_all();
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, hold one edge, release.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  // Stay in a timed phase with neutral inputs; return how many cycles it lasted.
  task automatic time_phase(input int ph, output int n);
    n = 0;
    while (32'(gf_bus.state_o) == 32'(ph) && n < 20) begin
      n++;
      cyc(0, 0, 0, 0, 5);
    end
  endtask

  int n;

  initial begin
    gf_bus.space_i = 1'b1;
    gf_bus.pause_i = 1'b0;
    gf_bus.bullet_collide_eagle_i = 1'b0;
    gf_bus.bullet_collide_player_i = 1'b0;
    gf_bus.enemy_left_i = 6'd5;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;

    // Space held through reset: no exit until released and pressed again.
    cyc(1, 0, 0, 0, 5);
    cyc(1, 0, 0, 0, 5);
    check("menu_hold", 32'(gf_bus.state_o), P_MENU);
    cyc(0, 0, 0, 0, 5);
    cyc(1, 0, 0, 0, 5);
    check("start", 32'(gf_bus.state_o), P_START);
    cyc(0, 0, 0, 0, 5);

    // Level 1 cleared, then level 2 cleared -> win.
    cyc(0, 0, 0, 0, 0);
    time_phase(P_LDONE, n);
    check("ldone_len", 32'(n), 4);
    check("ldone_to_wait", 32'(gf_bus.state_o), P_LWAIT);
    cyc(1, 0, 0, 0, 5);
    check("level_up", 32'(gf_bus.level_o), 2);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0);
    time_phase(P_LDONE, n);
    check("ldone2_len", 32'(n), 4);
    check("win", 32'(gf_bus.state_o), P_WIN);
    cyc(0, 0, 0, 0, 5);
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);

    // Two player hits: respawn, then game over.
    cyc(0, 0, 0, 1, 5);
    check("lives_after_hit", 32'(gf_bus.lives_o), 1);
    time_phase(P_RESP, n);
    check("respawn_len", 32'(n), 2);
    cyc(0, 0, 0, 1, 5);
    check("lives_zero", 32'(gf_bus.lives_o), 0);
    time_phase(P_OVERD, n);
    check("over_len", 32'(n), 3);
    check("game_over", 32'(gf_bus.state_o), P_GOVER);
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);
    check("lives_restored", 32'(gf_bus.lives_o), 2);

    // Eagle hit outranks level completion.
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 0, 1, 0, 0);
    check("eagle_priority", 32'(gf_bus.state_o), P_OVERD);
    check("eagle_level", 32'(gf_bus.level_o), 1);
    time_phase(P_OVERD, n);
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);

    // Pause: inputs ignored while paused; held key toggles once.
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 5);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 0);
    check("paused_hold", 32'(gf_bus.state_o), P_PAUSE);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 5);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 5);
    check("unpaused_hold", 32'(gf_bus.state_o), P_PLAY);

    // Reset during level-done of level 2 at counter 2.
    cyc(0, 0, 0, 0, 0);
    time_phase(P_LDONE, n);
    cyc(1, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 5);
    check("pre_reset_ldone", 32'(gf_bus.state_o), P_LDONE);
    rst = 1'b1;
    #1;
    check("rst_state", 32'(gf_bus.state_o), P_MENU);
    check("rst_level", 32'(gf_bus.level_o), 1);
    check("rst_flags", 32'(gf_bus.is_level_done_o), 0);
    check("rst_reset_game", 32'(gf_bus.reset_game_o), 1);
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
          ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 63)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Parametrised top-level game flow controller for the tank/eagle game. Sequences menu, play, pause, respawn, level-done, game-over and game-win phases.
- Drives one-cycle-registered phase flags, the game-logic reset, the current level and remaining lives.
- Sits between keyboard decode (space/pause keys) and the playfield, enemy and render blocks.

Parameters:
- NUM_LEVELS, 10, last level; completing it gives GAME_WIN.
- LEVEL_W, 4, width of level_o; must hold NUM_LEVELS.
- NUM_LIVES, 3, lives at game start (>=1).
- LIVES_W, 2, width of lives_o; must hold NUM_LIVES.
- ENEMY_W, 6, width of enemy_left_i.
- CNT_W, 24, delay counter width.
- DONE_DELAY, 12500000, cycles spent in LEVEL_DONE (>=1).
- OVER_DELAY, 12500000, cycles spent in OVER_DELAY (>=1).
- RESPAWN_DELAY, 6250000, cycles spent in RESPAWN (>=1).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- space_i  in  1  space key level; rising edge used.
- pause_i  in  1  pause key level; rising edge used.
- bullet_collide_eagle_i  in  1  eagle destroyed.
- bullet_collide_player_i  in  1  player tank destroyed.
- enemy_left_i  in  ENEMY_W  enemies remaining in the level.
- is_menu_o  out  1  menu phase.
- is_playing_o  out  1  active play.
- is_paused_o  out  1  paused.
- is_respawn_o  out  1  player respawn delay.
- is_level_done_o  out  1  level-done display/wait.
- is_game_over_o  out  1  game-over display/wait.
- is_game_win_o  out  1  win screen.
- reset_game_o  out  1  holds playfield logic in reset.
- level_o  out  LEVEL_W  current level, 1..NUM_LEVELS.
- lives_o  out  LIVES_W  lives remaining.
- state_o  out  4  encoded current state, for debug.

Behaviour:
- Reset values:
  - state MENU; all is_* outputs 0; reset_game_o 1.
  - level_o 1; lives_o NUM_LIVES; state_o MENU code; counter 0.
  - Key-history registers reset to 1, so a key held through reset gives no edge.
- Key edges:
  - space_rise = space_i & ~space_q; pause_rise likewise; history registered every cycle.
  - A held key never advances more than one state.
- Outputs are registered, decoded from the state being left/held. Flags lag the state by one cycle.
- Every cycle, outputs default to: flags 0, reset_game_o 1. The state sets the exceptions listed below.
- Delay counter:
  - Cleared on entry to any timed state; increments each cycle in it.
  - Exit when counter == DELAY-1, so the state lasts exactly DELAY cycles.
- MENU: is_menu_o=1; level_o<=1; lives_o<=NUM_LIVES. space_rise -> START.
- START: 1 cycle, reset_game_o=1 -> PLAYING.
- PLAYING: reset_game_o=0, is_playing_o=1. Priority, highest first:
  - eagle hit -> OVER_DELAY.
  - enemy_left_i==0 -> LEVEL_DONE.
  - player hit: lives_o==1 -> lives_o<=0, OVER_DELAY; else lives_o-1, RESPAWN.
  - pause_rise -> PAUSED.
- PAUSED: reset_game_o=0, is_paused_o=1.
  - Collision inputs and enemy_left_i are ignored.
  - pause_rise or space_rise -> PLAYING.
- RESPAWN (timed, RESPAWN_DELAY): is_respawn_o=1, reset_game_o=0; eagle hit -> OVER_DELAY; done -> PLAYING.
- LEVEL_DONE (timed, DONE_DELAY): is_level_done_o=1. Done -> GAME_WIN if level_o==NUM_LEVELS, else LEVEL_WAIT.
- LEVEL_WAIT: is_level_done_o=1. space_rise -> level_o+1, START.
- OVER_DELAY (timed, OVER_DELAY): is_game_over_o=1, reset_game_o=0 (freeze frame) -> GAME_OVER.
- GAME_OVER: is_game_over_o=1; space_rise -> MENU.
- GAME_WIN: is_game_win_o=1; space_rise -> MENU.
- Undefined state codes -> MENU.
- level_o never exceeds NUM_LEVELS; lives_o never underflows.
- reset_i mid-operation returns to MENU state and reset values asynchronously, regardless of the counter value.

Decomposition:
- Package game_pkg holds:
  - state enum game_state_e (4-bit: MENU, START, PLAYING, PAUSED, RESPAWN, LEVEL_DONE, LEVEL_WAIT, OVER_DELAY, GAME_OVER, GAME_WIN).
  - Default delay constants.
- One sub-module key_edge: rising-edge detector, reset value 1, instantiated twice.

Test Plan:
- Params DONE_DELAY=4, OVER_DELAY=3, RESPAWN_DELAY=2, NUM_LEVELS=2, NUM_LIVES=2.
- Reset with space held, release, press: no exit from MENU until the second press. Then START for 1 cycle, then PLAYING; reset_game_o 1 -> 0.
- In PLAYING, drive enemy_left_i=0:
  - LEVEL_DONE lasts exactly 4 cycles, then LEVEL_WAIT.
  - Space -> level_o=2, back to PLAYING.
  - enemy_left_i=0 again -> GAME_WIN after 4 cycles.
- Player hit twice:
  - First hit: lives_o 2 -> 1, RESPAWN for 2 cycles, then PLAYING.
  - Second hit: lives_o=0, OVER_DELAY for 3 cycles, then GAME_OVER; space -> MENU with lives_o=2.
- Eagle hit and enemy_left_i=0 in the same cycle -> OVER_DELAY, level_o unchanged.
- Pause press -> PAUSED:
  - Collisions and enemy_left_i=0 are ignored while paused.
  - Pause press again -> PLAYING.
  - A held pause key gives a single toggle.
- Assert reset_i during LEVEL_DONE at counter=2 -> immediate MENU, level_o=1, flags 0, reset_game_o=1.
